johnson_counter_decoder_32_bit: RTL

Receive-side companion to the 32-bit Johnson counter. It samples a 32-bit Johnson code word and decodes it to a 6-bit binary index in the range 0..63. It also checks that the code is a legal Johnson pattern and that consecutive samples step legally. It sits on the counter's output bus and feeds status and error information to a supervisor.

---
 rtl/johnson_pkg.sv | 34 +++
 rtl/johnson_index_decode.sv | 39 +++
 rtl/johnson_counter_decoder_32_bit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg
// Shared definitions for the 32-bit Johnson code receive path:
//   - code geometry (word width, number of legal states, index width)
//   - sync FSM state encoding
//   - jc_pattern(): regenerates the legal 32-bit code word for an index.
//     The decoder uses it for the legality check.
package johnson_pkg;

  localparam int JC_WIDTH  = 32;
  localparam int JC_STATES = 64;
  localparam int JC_IDX_W  = 6;

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } sync_state_e;

  // Index k in 0..32 is k ones packed from bit 0.
  // Index 32+m (m in 1..31) is 32-m ones packed from bit 31, so bit i is set
  // when i >= m, i.e. i >= k-32.
  function automatic logic [JC_WIDTH-1:0] jc_pattern(input logic [JC_IDX_W-1:0] idx);
    logic [JC_WIDTH-1:0] pat;
    pat = '0;
    for (int i = 0; i < JC_WIDTH; i++) begin
      if (int'(idx) <= JC_WIDTH) begin
        pat[i] = (i < int'(idx));
      end else begin
        pat[i] = (i >= (int'(idx) - JC_WIDTH));
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/johnson_index_decode.sv
// johnson_index_decode
// Purely combinational decode of a 32-bit Johnson code word.
// Ports:
//   code  [31:0] in  : sampled code word
//   index [5:0]  out : decoded index 0..63 (computed even for illegal codes)
//   legal        out : code matches the pattern regenerated from index
module johnson_index_decode
  import johnson_pkg::*;
(
  input  logic [JC_WIDTH-1:0] code,
  output logic [JC_IDX_W-1:0] index,
  output logic                legal
);

  // popcount of a 32-bit word is at most 32, which fits in 6 bits
  logic [JC_IDX_W-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < JC_WIDTH; i++) begin
      ones = ones + {{(JC_IDX_W-1){1'b0}}, code[i]};
    end
  end

  // Codes with bit 0 set are in the "filling" half (index = ones count).
  // Codes with bit 0 clear and at least one one are in the "draining" half:
  // index = 64 - ones, which in 6-bit arithmetic is simply -ones.
  always_comb begin
    index = '0;
    if (code[0]) begin
      index = ones;
    end else if (ones != '0) begin
      index = '0 - ones;
    end
  end

  assign legal = (code == jc_pattern(index));

endmodule

// File: rtl/johnson_counter_decoder_32_bit.sv
// johnson_counter_decoder_32_bit
// Receive-side decoder/checker for a 32-bit Johnson counter bus.
// Two-stage pipeline: stage 1 captures the strobed code word, stage 2
// decodes it, runs the sync FSM, updates the error counter and registers
// the result flags.
// Ports:
//   Clk_In                 in  : rising-edge clock
//   Reset_n_In             in  : asynchronous active-low reset
//   Enable_In              in  : output driver enable (outputs Z when low)
//   Code_In [31:0]         in  : Johnson code word
//   Code_Valid_In          in  : sample strobe for Code_In
//   Clear_Errors_In        in  : synchronous clear of the error counter
//   Index_Out [5:0]        out : decoded index (holds between samples)
//   Index_Valid_Out        out : one-cycle pulse per decoded sample
//   Illegal_Code_Flag_Out  out : pulse with Index_Valid_Out, code illegal
//   Step_Error_Flag_Out    out : pulse with Index_Valid_Out, bad step
//   Sync_Flag_Out          out : level, high while the FSM is in SYNC
//   Error_Count_Out        out : saturating count of illegal codes + step errors
// Handshake: Code_Valid_In is a strobe with no backpressure; every cycle it
// is high a sample is taken and exactly one Index_Valid_Out pulse follows
// two rising edges later (unless a reset intervenes).
module johnson_counter_decoder_32_bit
  import johnson_pkg::*;
#(
  parameter int ERR_CNT_W  = 8,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic                 Clk_In,
  input  logic                 Reset_n_In,
  input  logic                 Enable_In,
  input  logic [JC_WIDTH-1:0]  Code_In,
  input  logic                 Code_Valid_In,
  input  logic                 Clear_Errors_In,
  output logic [JC_IDX_W-1:0]  Index_Out,
  output logic                 Index_Valid_Out,
  output logic                 Illegal_Code_Flag_Out,
  output logic                 Step_Error_Flag_Out,
  output logic                 Sync_Flag_Out,
  output logic [ERR_CNT_W-1:0] Error_Count_Out
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [JC_IDX_W-1:0]  DELTA_ONE = JC_IDX_W'(1);

  // ---------------------------------------------------------------------------
  // Stage 1: capture
  // ---------------------------------------------------------------------------
  logic                s1_valid;
  logic [JC_WIDTH-1:0] s1_code;

  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else begin
      s1_valid <= Code_Valid_In;
      if (Code_Valid_In) begin
        s1_code <= Code_In;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: decode, FSM, counter
  // ---------------------------------------------------------------------------
  logic [JC_IDX_W-1:0] dec_index;
  logic                dec_legal;

  johnson_index_decode u_decode (
    .code  (s1_code),
    .index (dec_index),
    .legal (dec_legal)
  );

  sync_state_e         state_q, state_d;
  logic [JC_IDX_W-1:0] prev_q, prev_d;
  logic [JC_IDX_W-1:0] delta;
  logic                step_ok;
  logic                illegal_d, step_err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // Modulo-64 difference, so the 63 -> 0 wrap is a delta of 1.
  assign delta   = dec_index - prev_q;
  assign step_ok = (delta == DELTA_ONE) || (ALLOW_HOLD && (delta == '0));

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    illegal_d  = 1'b0;
    step_err_d = 1'b0;
    if (s1_valid) begin
      unique case (state_q)
        UNSYNC: begin
          // Acquire on the first legal code; there is no history to step-check.
          if (dec_legal) begin
            state_d = SYNC;
            prev_d  = dec_index;
          end else begin
            illegal_d = 1'b1;
          end
        end
        SYNC: begin
          if (!dec_legal) begin
            state_d   = UNSYNC;
            illegal_d = 1'b1;
          end else begin
            // A bad step is reported but we resync to the new index rather
            // than dropping lock, so a single glitch yields a single error.
            prev_d = dec_index;
            if (!step_ok) begin
              step_err_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = UNSYNC;
        end
      endcase
    end
  end

  // Illegal code and step error are mutually exclusive per sample, so the
  // counter never advances by more than one.
  always_comb begin
    cnt_d = cnt_q;
    if (Clear_Errors_In) begin
      cnt_d = '0;
    end else if ((illegal_d || step_err_d) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  logic [JC_IDX_W-1:0] index_q;
  logic                valid_q;
  logic                illegal_q;
  logic                step_err_q;

  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q    <= UNSYNC;
      prev_q     <= '0;
      cnt_q      <= '0;
      index_q    <= '0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      valid_q    <= s1_valid;
      illegal_q  <= illegal_d;
      step_err_q <= step_err_d;
      if (s1_valid) begin
        index_q <= dec_index;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output drivers: Enable_In only gates the bus, internal state keeps running.
  // ---------------------------------------------------------------------------
  assign Index_Out             = Enable_In ? index_q            : 'z;
  assign Index_Valid_Out       = Enable_In ? valid_q            : 1'bz;
  assign Illegal_Code_Flag_Out = Enable_In ? illegal_q          : 1'bz;
  assign Step_Error_Flag_Out   = Enable_In ? step_err_q         : 1'bz;
  assign Sync_Flag_Out         = Enable_In ? (state_q == SYNC)  : 1'bz;
  assign Error_Count_Out       = Enable_In ? cnt_q              : 'z;

endmodule
